imm_decode_ctrl: RTL and testbench



---
 rtl/imm_decode_ctrl.sv | 150 +++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// ============================================================================
// Module      : imm_decode_ctrl
// Description : LEGv8 immediate decoder feeding a 2-entry valid/ready buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_imm,
  output logic [2:0]  out_type,
  output logic [63:0] out_mask,
  output logic [31:0] imm_count
);

  localparam logic [2:0] TYPE_NONE  = 3'd0;
  localparam logic [2:0] TYPE_ALU12 = 3'd1;
  localparam logic [2:0] TYPE_MEM9  = 3'd2;
  localparam logic [2:0] TYPE_CBR19 = 3'd3;
  localparam logic [2:0] TYPE_BR26  = 3'd4;
  localparam logic [2:0] TYPE_MOVZ  = 3'd5;
  localparam logic [2:0] TYPE_MOVK  = 3'd6;

  logic [63:0] dec_imm;
  logic [2:0]  dec_type;
  logic [63:0] dec_mask;
  logic [5:0]  hw_shift;

  logic [63:0] imm_mem_q  [2];
  logic [63:0] imm_mem_d  [2];
  logic [2:0]  type_mem_q [2];
  logic [2:0]  type_mem_d [2];
  logic [63:0] mask_mem_q [2];
  logic [63:0] mask_mem_d [2];
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] imm_count_q, imm_count_d;
  logic        push;
  logic        pop;

  // First matching class wins; unmatched encodings fall through to NONE.
  always_comb begin
    dec_type = TYPE_NONE;
    dec_imm  = 64'd0;
    dec_mask = {64{1'b1}};
    hw_shift = {in_instr[22:21], 4'b0000};
    if (in_instr[31:26] == 6'b000101 || in_instr[31:26] == 6'b100101) begin
      dec_type = TYPE_BR26;
      dec_imm  = {{36{in_instr[25]}}, in_instr[25:0], 2'b00};
    end else if (in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b10110101 ||
                 in_instr[31:24] == 8'b01010100) begin
      dec_type = TYPE_CBR19;
      dec_imm  = {{43{in_instr[23]}}, in_instr[23:5], 2'b00};
    end else if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      dec_type = TYPE_MEM9;
      dec_imm  = {{55{in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:23] == 9'b110100101) begin
      dec_type = TYPE_MOVZ;
      dec_imm  = {48'd0, in_instr[20:5]} << hw_shift;
    end else if (in_instr[31:23] == 9'b111100101) begin
      dec_type = TYPE_MOVK;
      dec_imm  = {48'd0, in_instr[20:5]} << hw_shift;
      dec_mask = ~(64'h0000_0000_0000_FFFF << hw_shift);
    end else begin
      case (in_instr[31:22])
        10'b1001000100, 10'b1101000100, 10'b1011000100, 10'b1111000100,
        10'b1001001000, 10'b1011001000, 10'b1101001000: begin
          dec_type = TYPE_ALU12;
          dec_imm  = {52'd0, in_instr[21:10]};
        end
        default: ;
      endcase
    end
  end

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_imm   = imm_mem_q[rd_ptr_q];
  assign out_type  = type_mem_q[rd_ptr_q];
  assign out_mask  = mask_mem_q[rd_ptr_q];
  assign imm_count = imm_count_q;

  always_comb begin
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    imm_mem_d   = imm_mem_q;
    type_mem_d  = type_mem_q;
    mask_mem_d  = mask_mem_q;
    imm_count_d = imm_count_q;

    // Counts accepted entries even when the same cycle is flushed.
    if (push && dec_type != TYPE_NONE) imm_count_d = imm_count_q + 32'd1;

    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        imm_mem_d[wr_ptr_q]  = dec_imm;
        type_mem_d[wr_ptr_q] = dec_type;
        mask_mem_d[wr_ptr_q] = dec_mask;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      imm_count_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        imm_mem_q[i]  <= 64'd0;
        type_mem_q[i] <= TYPE_NONE;
        mask_mem_q[i] <= {64{1'b1}};
      end
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      imm_count_q <= imm_count_d;
      imm_mem_q   <= imm_mem_d;
      type_mem_q  <= type_mem_d;
      mask_mem_q  <= mask_mem_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
// ============================================================================
// Module      : tb_imm_decode_ctrl
// Description : Directed + random bench for imm_decode_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_type;
  logic [63:0] out_mask;
  logic [31:0] imm_count;

  imm_decode_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_type  (out_type),
    .out_mask  (out_mask),
    .imm_count (imm_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic [63:0] mask;
  } ent_t;

  ent_t        mq[$];
  logic [2:0]  popped[$];
  logic [31:0] m_cnt;
  int          n_cmp = 0;
  int          n_mis = 0;

  logic [7:0]  cbr_ops [3] = '{8'hB4, 8'hB5, 8'h54};
  logic [9:0]  alu_ops [7] = '{10'h244, 10'h344, 10'h2C4, 10'h3C4, 10'h248, 10'h2C8, 10'h348};

  localparam logic [31:0] I_ADDI = 32'h913FFC41;
  localparam logic [31:0] I_LDUR = 32'hF85F8000;
  localparam logic [31:0] I_B    = 32'h17FFFFFF;
  localparam logic [31:0] I_CBZ  = 32'hB4000020;
  localparam logic [31:0] I_MOVK = 32'hF2D7DDE0;
  localparam logic [31:0] I_MOVZ = 32'hD2F00000;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  // Reference decode from the instruction-set rules, using plain integer arithmetic.
  function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm,
                                     output logic [2:0] ty, output logic [63:0] mask);
    longint      v;
    logic [63:0] pw;
    imm  = 64'd0;
    ty   = 3'd0;
    mask = ONES;
    pw   = 64'd1;
    for (int i = 0; i < 16 * int'(w[22:21]); i++) pw = pw * 64'd2;
    if (w[31:26] == 6'h05 || w[31:26] == 6'h25) begin
      v = longint'(w[25:0]);
      if (v >= 64'sd33554432) v = v - 64'sd67108864;
      imm = 64'(v * 4);
      ty  = 3'd4;
    end else if (w[31:24] inside {8'hB4, 8'hB5, 8'h54}) begin
      v = longint'(w[23:5]);
      if (v >= 64'sd262144) v = v - 64'sd524288;
      imm = 64'(v * 4);
      ty  = 3'd3;
    end else if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      v = longint'(w[20:12]);
      if (v >= 64'sd256) v = v - 64'sd512;
      imm = 64'(v);
      ty  = 3'd2;
    end else if (w[31:23] == 9'h1A5) begin
      imm = 64'(w[20:5]) * pw;
      ty  = 3'd5;
    end else if (w[31:23] == 9'h1E5) begin
      imm  = 64'(w[20:5]) * pw;
      mask = ~(64'hFFFF * pw);
      ty   = 3'd6;
    end else if (w[31:22] inside {10'h244, 10'h344, 10'h2C4, 10'h3C4, 10'h248, 10'h2C8, 10'h348}) begin
      imm = 64'(w[21:10]);
      ty  = 3'd1;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      1: r[31:24] = cbr_ops[$urandom_range(0, 2)];
      2: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0;
      3: r[31:23] = 9'h1A5;
      4: r[31:23] = 9'h1E5;
      5: r[31:22] = alu_ops[$urandom_range(0, 6)];
      6: ;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("imm_count", 64'(imm_count), 64'(m_cnt));
    if (mq.size() != 0) begin
      chk("head_imm", out_imm, mq[0].imm);
      chk("head_type", 64'(out_type), 64'(mq[0].ty));
      chk("head_mask", out_mask, mq[0].mask);
    end
  endtask

  // Called at a falling edge: check, drive, advance model across the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic push, pop;
    ent_t e;
    check_all();
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    push = v && (mq.size() < 2);
    pop  = ordy && (mq.size() != 0);
    ref_decode(ins, e.imm, e.ty, e.mask);
    @(posedge clk);
    if (push && e.ty != 3'd0) m_cnt = m_cnt + 32'd1;
    if (fl) mq.delete();
    else begin
      if (pop) begin
        popped.push_back(mq[0].ty);
        void'(mq.pop_front());
      end
      if (push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] ins, input logic [2:0] ty,
                          input logic [63:0] imm, input logic [63:0] mask);
    step(1'b1, ins, 1'b0, 1'b0);
    chk({tag, "_type"}, 64'(out_type), 64'(ty));
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_mask"}, out_mask, mask);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] cnt_before;
    int          n_pop_before;
    reset_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0; flush = 1'b0;
    m_cnt = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm_count", 64'(imm_count), 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_type", 64'(out_type), 64'd0);
    chk("rst_out_mask", out_mask, ONES);
    reset_n = 1'b1;

    step(1'b1, I_ADDI, 1'b1, 1'b0);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_type", 64'(out_type), 64'd1);
    chk("addi_imm", out_imm, 64'h0000_0000_0000_0FFF);
    chk("addi_mask", out_mask, ONES);
    chk("addi_count", 64'(imm_count), 64'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    directed("ldur", I_LDUR, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, ONES);
    directed("b",    I_B,    3'd4, 64'hFFFF_FFFF_FFFF_FFFC, ONES);
    directed("cbz",  I_CBZ,  3'd3, 64'h0000_0000_0000_0004, ONES);
    directed("movk", I_MOVK, 3'd6, 64'h0000_BEEF_0000_0000, 64'hFFFF_0000_FFFF_FFFF);
    directed("movz", I_MOVZ, 3'd5, 64'h8000_0000_0000_0000, ONES);

    // Back-pressure: A, B absorbed, C held until space frees up.
    popped.delete();
    step(1'b1, I_ADDI, 1'b0, 1'b0);
    step(1'b1, I_LDUR, 1'b0, 1'b0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    step(1'b1, I_B, 1'b0, 1'b0);
    step(1'b1, I_B, 1'b1, 1'b0);
    step(1'b1, I_B, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("bp_npop", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      chk("bp_order0", 64'(popped[0]), 64'd1);
      chk("bp_order1", 64'(popped[1]), 64'd2);
      chk("bp_order2", 64'(popped[2]), 64'd4);
    end

    cnt_before = m_cnt;
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    chk("none_type", 64'(out_type), 64'd0);
    chk("none_imm", out_imm, 64'd0);
    chk("none_count", 64'(imm_count), 64'(cnt_before));
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with a full buffer while both handshakes are offered.
    n_pop_before = popped.size();
    step(1'b1, I_ADDI, 1'b0, 1'b0);
    step(1'b1, I_LDUR, 1'b0, 1'b0);
    step(1'b1, I_B, 1'b1, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_emit", 64'(popped.size()), 64'(n_pop_before));
    step(1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    step(1'b1, I_ADDI, 1'b0, 1'b0);
    step(1'b1, I_MOVK, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_imm", out_imm, 64'd0);
    chk("arst_count", 64'(imm_count), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    mq.delete();
    m_cnt = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, I_ADDI, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Counter wrap: preload the counter and check the next value it would take.
    force dut.imm_count_q = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_instr = I_ADDI; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("wrap_preload", 64'(imm_count), 64'h0000_0000_FFFF_FFFF);
    chk("wrap_next", 64'(dut.imm_count_d), 64'd0);
    in_valid = 1'b0;
    #1;
    release dut.imm_count_q;
    reset_n = 1'b0;
    mq.delete();
    m_cnt = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
